// File: rtl/counter_pkg.sv
// Shared defaults and the count word type for the async-reset event counter.
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH_DEFAULT = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT   = 2;

  typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage : counter_pkg

// File: rtl/async_reset_counter_reset_sync.sv
// Reset synchronizer: asserts immediately when reset falls and releases
// on the STAGES-th rising clk edge after reset returns high.
module reset_sync
  import counter_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic rst_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n = sync_q[STAGES-1];

endmodule : reset_sync

// File: rtl/async_reset_counter.sv
// Free-running up-counter with enable, terminal-count wrap and a registered
// one-cycle carry pulse; reset asserts asynchronously, releases synchronously.
module async_reset_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNTER_WIDTH_DEFAULT,
  parameter int unsigned MAX_VALUE   = (2**WIDTH) - 1,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
    $error("async_reset_counter: WIDTH must be in 1..31");
  end
  if (MAX_VALUE < 1 || MAX_VALUE > (2**WIDTH) - 1) begin : g_bad_max
    $error("async_reset_counter: MAX_VALUE must be in 1..2**WIDTH-1");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("async_reset_counter: RESET_VALUE must not exceed MAX_VALUE");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("async_reset_counter: SYNC_STAGES must be at least 2");
  end

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic             rst_n;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             carry_q;
  logic             carry_d;
  logic [WIDTH:0]   inc;
  logic             wrap;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk   (clk),
    .reset (reset),
    .rst_n (rst_n)
  );

  always_comb begin
    inc      = {1'b0, result_q} + {{WIDTH{1'b0}}, 1'b1};
    // A carry-out of the widened increment only happens at all-ones, which is
    // then necessarily the terminal count.
    wrap     = (result_q == MAX_W) || inc[WIDTH];
    result_d = result_q;
    carry_d  = 1'b0;
    if (ena) begin
      if (wrap) begin
        result_d = '0;
        carry_d  = 1'b1;
      end else begin
        result_d = inc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= RESET_W;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;

  a_carry_means_zero : assert property (
    @(posedge clk) disable iff (!rst_n) carry_q |-> (result_q == '0)
  );

  a_carry_needs_ena : assert property (
    @(posedge clk) disable iff (!rst_n) carry_q |-> $past(ena)
  );

  a_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) result_q <= MAX_W
  );

endmodule : async_reset_counter

// File: tb/tb_async_reset_counter.sv
// Directed bench for async_reset_counter: default build plus a MAX_VALUE=9 build.
module tb_async_reset_counter;
  import counter_pkg::*;

  logic   clk     = 1'b0;
  logic   clk_run = 1'b0;
  logic   reset   = 1'b1;
  logic   ena     = 1'b0;
  logic   ena9    = 1'b0;
  count_t result;
  count_t result9;
  logic   carry;
  logic   carry9;

  int n_pass = 0;
  int n_chk  = 0;

  async_reset_counter dut (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .result (result),
    .carry  (carry)
  );

  async_reset_counter #(
    .WIDTH     (8),
    .MAX_VALUE (9)
  ) dut9 (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena9),
    .result (result9),
    .carry  (carry9)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (result !== 8'h00) $display("FAIL reset_result: got %h expected 00", result);
    else n_pass++;
    n_chk++;
    if (carry !== 1'b0) $display("FAIL reset_carry: got %b expected 0", carry);
    else n_pass++;
    n_chk++;
    if (result9 !== 8'h00) $display("FAIL reset_result9: got %h expected 00", result9);
    else n_pass++;
    n_chk++;
    if (carry9 !== 1'b0) $display("FAIL reset_carry9: got %b expected 0", carry9);
    else n_pass++;
    #2 clk_run = 1'b1;
  endtask

  task automatic test_release_count();
    @(negedge clk);
    ena   = 1'b1;
    reset = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      n_chk++;
      if (result !== 8'h00) $display("FAIL release_edge%0d: got %h expected 00", e, result);
      else n_pass++;
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if (result !== 8'h0A) $display("FAIL count_12_edges: got %h expected 0a", result);
    else n_pass++;
    n_chk++;
    if (carry !== 1'b0) $display("FAIL count_carry: got %b expected 0", carry);
    else n_pass++;
  endtask

  task automatic test_hold();
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (result !== 8'h0A || carry !== 1'b0)
        $display("FAIL hold_%0d: got result=%h carry=%b expected 0a/0", i, result, carry);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_default();
    int seen;
    seen = 0;
    ena  = 1'b1;
    repeat (244) begin
      @(negedge clk);
      if (carry !== 1'b0) seen++;
    end
    n_chk++;
    if (seen != 0) $display("FAIL climb_carry: got %0d carry cycles expected 0", seen);
    else n_pass++;
    n_chk++;
    if (result !== 8'hFE) $display("FAIL climb_result: got %h expected fe", result);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result !== 8'hFF || carry !== 1'b0)
      $display("FAIL wrap_ff: got %h/%b expected ff/0", result, carry);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result !== 8'h00 || carry !== 1'b1)
      $display("FAIL wrap_00: got %h/%b expected 00/1", result, carry);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result !== 8'h01 || carry !== 1'b0)
      $display("FAIL wrap_01: got %h/%b expected 01/0", result, carry);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    repeat (54) @(negedge clk);
    n_chk++;
    if (result !== 8'h37) $display("FAIL pre_reset: got %h expected 37", result);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if (result !== 8'h00 || carry !== 1'b0)
      $display("FAIL mid_reset_immediate: got %h/%b expected 00/0", result, carry);
    else n_pass++;
    #2 reset = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      n_chk++;
      if (result !== 8'h00) $display("FAIL mid_release_edge%0d: got %h expected 00", e, result);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (result !== 8'h01) $display("FAIL mid_first_count: got %h expected 01", result);
    else n_pass++;
  endtask

  task automatic test_wrap9();
    ena  = 1'b0;
    ena9 = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (result9 !== 8'd8 || carry9 !== 1'b0)
      $display("FAIL wrap9_8: got %0d/%b expected 8/0", result9, carry9);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result9 !== 8'd9 || carry9 !== 1'b0)
      $display("FAIL wrap9_9: got %0d/%b expected 9/0", result9, carry9);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result9 !== 8'd0 || carry9 !== 1'b1)
      $display("FAIL wrap9_0: got %0d/%b expected 0/1", result9, carry9);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (result9 !== 8'd1 || carry9 !== 1'b0)
      $display("FAIL wrap9_1: got %0d/%b expected 1/0", result9, carry9);
    else n_pass++;
    n_chk++;
    if (result !== 8'h01) $display("FAIL wrap9_main_hold: got %h expected 01", result);
    else n_pass++;
    ena9 = 1'b0;
  endtask

  task automatic test_toggle();
    @(negedge clk);
    reset = 1'b0;
    ena   = 1'b0;
    #1;
    n_chk++;
    if (result !== 8'h00 || carry !== 1'b0)
      $display("FAIL toggle_reset: got %h/%b expected 00/0", result, carry);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ena = (i % 2 == 0);
      @(negedge clk);
      n_chk++;
      if (carry !== 1'b0) $display("FAIL toggle_carry_%0d: got %b expected 0", i, carry);
      else n_pass++;
    end
    n_chk++;
    if (result !== 8'h04) $display("FAIL toggle_result: got %h expected 04", result);
    else n_pass++;
    ena = 1'b0;
  endtask

  initial begin
    test_reset();
    test_release_count();
    test_hold();
    test_wrap_default();
    test_mid_reset();
    test_wrap9();
    test_toggle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_async_reset_counter

// File: doc/async_reset_counter.md
Name: async_reset_counter

Overview:
- Free-running up-counter with clock enable, single clock domain, asynchronous active-low reset.
- Default width 8 bits; counts 0..MAX_VALUE and wraps, with a one-cycle carry pulse on wrap.
- Used as a general event/cycle counter in datapath and control logic.
- Reset is asserted asynchronously and released synchronously via an internal reset synchronizer.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VALUE, 2**WIDTH-1, terminal count. Must satisfy 1 <= MAX_VALUE <= 2**WIDTH-1. The counter wraps to 0 after this value.
- RESET_VALUE, 0, value loaded on reset. Must satisfy RESET_VALUE <= MAX_VALUE.
- SYNC_STAGES, 2, flops in the reset-release synchronizer. Must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- ena  input  1  count enable, sampled on rising clk.
- result  output  WIDTH  current count, registered.
- carry  output  1  registered pulse, high for one cycle after a wrap from MAX_VALUE to 0.

Behaviour:
- Reset assertion (reset=0):
  - result=RESET_VALUE and carry=0 immediately, with no clock edge required.
  - Both outputs hold these values for as long as reset=0.
- Reset release:
  - reset rising is synchronized through SYNC_STAGES flops.
  - The internal reset deasserts on the SYNC_STAGES-th rising clk edge after release.
  - The first counting edge is the one after that. With the default of 2, ena is ignored on the first 2 edges after release.
- Counting, on each rising clk edge with internal reset inactive:
  - ena=1 and result<MAX_VALUE: result <= result+1, carry <= 0.
  - ena=1 and result==MAX_VALUE: result <= 0, carry <= 1.
  - ena=0: result holds, carry <= 0.
- Carry timing:
  - carry is high for exactly one cycle per wrap.
  - It is never high while ena was 0 on the preceding edge.
- Latency: result reflects ena one edge later. There is no combinational path from ena to any output.
- Arithmetic: unsigned, modulo MAX_VALUE+1, no saturation. The increment is computed at WIDTH+1 bits, so the default 255->0 wrap creates no overflow corner.
- Reset mid-operation: an async reset at any phase (including between edges or coincident with an edge) forces result=RESET_VALUE and carry=0. Any pending carry is discarded.
- ena toggling: ena is honoured on every edge independently; there is no minimum on/off time.
- Before the first reset, output values are undefined. The system must apply reset before relying on result.

Decomposition:
- Shared package (counter_pkg) holds:
  - COUNTER_WIDTH_DEFAULT=8
  - SYNC_STAGES_DEFAULT=2
  - a typedef for the count word.
- One sub-module is natural: reset_sync, a parameterized async-assert/sync-deassert synchronizer. It takes clk and reset and produces an internal active-low rst_n.
- The top level holds:
  - the count register
  - the wrap compare
  - the carry register
  - parameter legality checks (elaboration-time assertions on MAX_VALUE, RESET_VALUE, SYNC_STAGES).

Test Plan:
- Async reset: hold clk at 0, drive reset=0 -> result=0x00 and carry=0 with no clock edge.
- Sync release plus count (10 ns clock): release reset with ena=1 and run 12 edges -> result=0x00 after edges 1-2, then 0x0A after edge 12.
- Hold: from result=0x0A, drive ena=0 for 20 edges -> result stays 0x0A and carry stays 0.
- Wrap:
  - Default: count from 0xFE with ena=1 -> 0xFF, then 0x00 with carry=1 for exactly one cycle, then 0x01 with carry=0.
  - MAX_VALUE=9 build: sequence 8, 9, 0 (carry=1), 1.
- Mid-operation reset: at result=0x37, pulse reset low for 3 ns between edges -> result=0x00 immediately. After release with ena=1, result is still 0x00 after 2 edges, then increments.
- Enable toggling: alternate ena 1/0 every edge for 8 edges from 0 -> result=0x04, carry never asserted.
